serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/serial_subtractor_full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic family: FSM state encoding
// and the RUN/DONE transition rule reused by the serial datapaths.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // RUN ignores start; DONE can re-enter RUN directly for back-to-back operation.
    function automatic state_t next_state(input state_t cur, input logic start, input logic last);
        state_t nxt;
        case (cur)
            S_IDLE:  nxt = start ? S_RUN : S_IDLE;
            S_RUN:   nxt = last  ? S_DONE : S_RUN;
            S_DONE:  nxt = start ? S_RUN : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two half-subtractor stages.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hd_s;
    logic hb1_s;
    logic hb2_s;

    // Stage 1: a-b; stage 2: subtract the incoming borrow; either stage may borrow.
    always_comb begin
        hd_s  = a ^ b;
        hb1_s = ~a & b;
        hb2_s = ~hd_s & bin;
        d     = hd_s ^ bin;
        bout  = hb1_s | hb2_s;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, with start/ready/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Z
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-2:0] sd_r;
    logic [WIDTH-1:0] sd_nxt_s;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             last_s;
    logic             d_s;
    logic             bo_s;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] d_r;
    logic             bout_r;
    logic             z_r;

    full_subtractor u_fs (
        .a    (sa_r[0]),
        .b    (sb_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bo_s)
    );

    // Accept/last-bit decode; sd_nxt_s is the full difference once the last bit is in.
    always_comb begin
        accept_s    = start & ready_r;
        last_s      = (state_r == S_RUN) && (cnt_r == CNT_LAST);
        sd_nxt_s    = {d_s, sd_r};
        state_nxt_s = next_state(state_r, start, last_s);
    end

    // FSM state register with handshake flags decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_DONE);
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Operand shift registers, partial difference, borrow flop and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            sd_r  <= {(WIDTH-1){1'b0}};
            br_r  <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            sa_r  <= A;
            sb_r  <= B;
            br_r  <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == S_RUN) begin
            sa_r <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r <= {1'b0, sb_r[WIDTH-1:1]};
            sd_r <= sd_nxt_s[WIDTH-1:1];
            br_r <= bo_s;
            if (!last_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Result registers: updated only on the edge that completes the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r    <= {WIDTH{1'b0}};
            bout_r <= 1'b0;
            z_r    <= 1'b0;
        end else if (last_s) begin
            d_r    <= sd_nxt_s;
            bout_r <= bo_s;
            z_r    <= (sd_nxt_s == {WIDTH{1'b0}});
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign D     = d_r;
    assign Bout  = bout_r;
    assign Z     = z_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed scenarios, WIDTH=4 sweep.
module tb_serial_subtractor;

    typedef struct packed {
        logic       bout;
        logic [7:0] d;
        logic       z;
    } exp8_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       ready8, busy8, done8, bout8, z8;
    logic [7:0] d8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = 4'h0;
    logic [3:0] b4 = 4'h0;
    logic       ready4, busy4, done4, bout4, z4;
    logic [3:0] d4;

    int total = 0;
    int bad   = 0;
    exp8_t      q8[$];
    logic [4:0] q4[$];

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .ready(ready8), .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .Z(z8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
        .ready(ready4), .busy(busy4), .done(done4), .D(d4), .Bout(bout4), .Z(z4)
    );

    always #5 clk = ~clk;

    function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b};
        return {r[8], r[7:0], (r[7:0] == 8'h00)};
    endfunction

    // One-cycle start pulse; returns at the falling edge after the accepting edge.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(model8(a, b));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        q4.push_back({1'b0, a} - {1'b0, b});
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop8(output exp8_t e);
        if (q8.size() > 0) e = q8.pop_front();
        else e = 10'h3FF;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ready8, busy8, done8, bout8, z8, d8} !== {5'b10000, 8'h00}) begin
            bad++; $display("FAIL reset8_held: got rbd_bz_d=%b req=%b", {ready8, busy8, done8, bout8, z8, d8}, {5'b10000, 8'h00});
        end
        total++;
        if ({ready4, busy4, done4, bout4, z4, d4} !== {5'b10000, 4'h0}) begin
            bad++; $display("FAIL reset4_held: got=%b req=%b", {ready4, busy4, done4, bout4, z4, d4}, {5'b10000, 4'h0});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            bad++; $display("FAIL reset8_released: got rbd=%b req=100", {ready8, busy8, done8});
        end
    endtask

    task automatic test_basic;
        logic [7:0] ta[4] = '{8'h5A, 8'h00, 8'hFF, 8'h80};
        logic [7:0] tb[4] = '{8'h3C, 8'hFF, 8'hFF, 8'h7F};
        exp8_t e;
        int n;
        for (int i = 0; i < 4; i++) begin
            drive8(ta[i], tb[i]);
            wait_done8(n);
            total++;
            if (n !== 8) begin
                bad++; $display("FAIL basic_latency[%0d]: got %0d req 8", i, n);
            end
            pop8(e);
            total++;
            if ({bout8, d8, z8} !== e) begin
                bad++; $display("FAIL basic_result[%0d]: got bout/d/z=%b/%h/%b req %b/%h/%b", i, bout8, d8, z8, e.bout, e.d, e.z);
            end
            @(negedge clk);
            total++;
            if (done8 !== 1'b0) begin
                bad++; $display("FAIL basic_pulse[%0d]: done got %b req 0", i, done8);
            end
        end
    endtask

    task automatic test_borrow;
        exp8_t e;
        int busy_cycles = 0;
        drive8(8'h00, 8'h01);
        for (int i = 0; i < 8; i++) begin
            if ({ready8, busy8} === 2'b01) busy_cycles++;
            @(negedge clk);
        end
        total++;
        if (busy_cycles !== 8) begin
            bad++; $display("FAIL borrow_busy_cycles: got %0d req 8", busy_cycles);
        end
        total++;
        if ({done8, ready8, busy8} !== 3'b110) begin
            bad++; $display("FAIL borrow_done_flags: got drb=%b req 110", {done8, ready8, busy8});
        end
        pop8(e);
        total++;
        if ({bout8, d8, z8} !== e) begin
            bad++; $display("FAIL borrow_result: got %b/%h/%b req %b/%h/%b", bout8, d8, z8, e.bout, e.d, e.z);
        end
    endtask

    task automatic test_back_to_back;
        exp8_t e;
        int n;
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h77; start8 = 1'b1;
        q8.push_back(model8(8'h77, 8'h77));
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01;
        wait_done8(n);
        total++;
        if (n !== 8) begin
            bad++; $display("FAIL b2b_first_latency: got %0d req 8", n);
        end
        pop8(e);
        total++;
        if ({bout8, d8, z8} !== e) begin
            bad++; $display("FAIL b2b_first_result: got %b/%h/%b req %b/%h/%b", bout8, d8, z8, e.bout, e.d, e.z);
        end
        q8.push_back(model8(8'h10, 8'h01));
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        total++;
        if (n + 1 !== 9) begin
            bad++; $display("FAIL b2b_spacing: got %0d cycles req 9", n + 1);
        end
        pop8(e);
        total++;
        if ({bout8, d8, z8} !== e) begin
            bad++; $display("FAIL b2b_second_result: got %b/%h/%b req %b/%h/%b", bout8, d8, z8, e.bout, e.d, e.z);
        end
    endtask

    task automatic test_ignore_mid_run;
        exp8_t e;
        int n;
        drive8(8'hC3, 8'h42);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        total++;
        if (n !== 5) begin
            bad++; $display("FAIL ignore_latency: got %0d req 5", n);
        end
        pop8(e);
        total++;
        if ({bout8, d8, z8} !== e) begin
            bad++; $display("FAIL ignore_result: got %b/%h/%b req %b/%h/%b", bout8, d8, z8, e.bout, e.d, e.z);
        end
    endtask

    task automatic test_reset_mid_run;
        exp8_t e;
        int n;
        int stray = 0;
        drive8(8'hA5, 8'h0F);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (d8 !== 8'h81) begin
            bad++; $display("FAIL hold_during_run: D got %h req 81", d8);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ready8, busy8, done8, bout8, z8, d8} !== {5'b10000, 8'h00}) begin
            bad++; $display("FAIL async_reset: got=%b req=%b", {ready8, busy8, done8, bout8, z8, d8}, {5'b10000, 8'h00});
        end
        pop8(e);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 !== 1'b0 || ready8 !== 1'b1) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL no_done_after_reset: got %0d bad cycles req 0", stray);
        end
        drive8(8'hA5, 8'h0F);
        wait_done8(n);
        pop8(e);
        total++;
        if (n !== 8 || {bout8, d8, z8} !== e) begin
            bad++; $display("FAIL post_reset_op: got lat=%0d %b/%h/%b req lat=8 %b/%h/%b", n, bout8, d8, z8, e.bout, e.d, e.z);
        end
    endtask

    task automatic test_sweep4;
        logic [4:0] e;
        int n;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive4(4'(a), 4'(b));
                wait_done4(n);
                e = (q4.size() > 0) ? q4.pop_front() : 5'h1F;
                total++;
                if (n !== 4 || {bout4, d4} !== e || z4 !== (e[3:0] == 4'h0)) begin
                    bad++; $display("FAIL sweep4 a=%h b=%h: got lat=%0d {bout,d}=%b z=%b req lat=4 %b z=%b",
                                    a[3:0], b[3:0], n, {bout4, d4}, z4, e, (e[3:0] == 4'h0));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_borrow;
        test_back_to_back;
        test_ignore_mid_run;
        test_reset_mid_run;
        test_sweep4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
